// File: rtl/fmax_reduce_if.sv
// Handshake bundle for the vector fmax reducer: start/len command, element
// stream in, and the held result out.
interface fmax_reduce_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      max_out;
  logic [LEN_W-1:0] max_idx;
  logic             nan_flag;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, max_out, max_idx, nan_flag
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, max_out, max_idx, nan_flag
  );
endinterface

// File: rtl/fmax_reduce_ctrl.sv
// Streams a vector of FP32 operands through a maxNum compare and holds the
// running maximum plus the index of its first occurrence until consumed.
module fmax_reduce_ctrl #(
  parameter int          LEN_W = 8,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input logic          clk,
  input logic          rst,
  fmax_reduce_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [31:0]      acc;
  logic [LEN_W-1:0] acc_idx;
  logic             acc_nan;
  logic             nan_q;

  logic accept, last, in_nan, take;

  // Sign-magnitude to monotonic unsigned key: -inf < ... < -0 < +0 < ... < +inf.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  assign accept = bus.in_valid && bus.in_ready;
  // In FIRST count is 0, so this also covers len==1.
  assign last   = (count == len_q - 1'b1);
  assign in_nan = is_nan(bus.in_data);
  // A NaN never wins; any number beats a NaN accumulator; ties keep the earlier index.
  assign take   = !in_nan && (acc_nan || (ord_key(bus.in_data) > ord_key(acc)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : FIRST;
      FIRST: if (accept)    state_nxt = last ? DONE : RUN;
      RUN:   if (accept && last) state_nxt = DONE;
      DONE:  if (bus.out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      count   <= '0;
      acc     <= '0;
      acc_idx <= '0;
      acc_nan <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          len_q   <= bus.len;
          count   <= '0;
          acc_idx <= '0;
          acc_nan <= 1'b0;
          nan_q   <= 1'b0;
          if (bus.len == '0) acc <= NEG_INF;
        end
        FIRST: if (accept) begin
          acc     <= bus.in_data;
          acc_idx <= '0;
          acc_nan <= in_nan;
          nan_q   <= in_nan;
          count   <= LEN_W'(1);
        end
        RUN: if (accept) begin
          if (take) begin
            acc     <= bus.in_data;
            acc_idx <= count;
            acc_nan <= 1'b0;
          end
          nan_q <= nan_q | in_nan;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == FIRST) || (state == RUN);
  assign bus.out_valid = (state == DONE);
  // An all-NaN vector reports the canonical quiet NaN, not the payload seen.
  assign bus.max_out   = acc_nan ? QNAN : acc;
  assign bus.max_idx   = acc_idx;
  assign bus.nan_flag  = nan_q;

endmodule
